// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU results with
// buffered load returns and tracks in-flight loads for decode hazards.
module rf_writeback_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic [31:0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t           mem [DEPTH];
    wb_t           head;
    logic [AW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve, starve_nxt;
    logic [31:0]   pend_nxt;
    logic          fifo_ne, full, force_fifo, alu_win, fifo_win, push;

    assign fifo_ne    = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign head       = mem[rptr];
    // The FIFO gets a guaranteed slot once the ALU has hogged the port long enough.
    assign force_fifo = fifo_ne && (starve == SW'(STARVE_MAX));
    assign alu_win    = alu_valid && !force_fifo;
    assign fifo_win   = fifo_ne && !alu_win;
    // Handshakes are held low while in reset so nothing is lost or falsely accepted.
    assign alu_ready  = alu_win && !RESET;
    assign lsu_ready  = !full && !RESET;
    // Loads to x0 are acknowledged but dropped.
    assign push       = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    // pending[0] is held at zero, so x0 can never raise a hazard.
    assign hazard     = pending[rs1] | pending[rs2] | pending[dec_rd];

    // Load-data storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= '{rd: lsu_rd, data: lsu_data};
    end

    // FIFO pointers and occupancy; power-of-two depth makes pointer wrap free.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)     wptr <= wptr + AW'(1);
            if (fifo_win) rptr <= rptr + AW'(1);
            case ({push, fifo_win})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Starve counter: counts ALU wins over a waiting FIFO; it cannot pass
    // STARVE_MAX because reaching it forces a FIFO win that clears it.
    always_comb begin
        starve_nxt = '0;
        if (alu_win && fifo_ne) starve_nxt = starve + SW'(1);
    end

    // Scoreboard next state: drain clears, issue sets, and set wins a tie.
    always_comb begin
        pend_nxt = pending;
        if (fifo_win) pend_nxt[head.rd] = 1'b0;
        if (ld_issue) pend_nxt[ld_issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Registered write port plus arbitration and scoreboard state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            A3      <= '0;
            WD3     <= '0;
            WE3     <= 1'b0;
            starve  <= '0;
            pending <= '0;
        end else begin
            starve  <= starve_nxt;
            pending <= pend_nxt;
            if (alu_win) begin
                A3  <= alu_rd;
                WD3 <= alu_data;
                WE3 <= (alu_rd != 5'd0);
            end else if (fifo_win) begin
                A3  <= head.rd;
                WD3 <= head.data;
                WE3 <= 1'b1;
            end else begin
                WE3 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized scoreboard bench for rf_writeback_arbiter with a queue-level model.
module tb_rf_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int SM    = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready, ld_issue, hazard, WE3;
    logic [4:0]  alu_rd, lsu_rd, ld_issue_rd, rs1, rs2, dec_rd, A3;
    logic [31:0] alu_data, lsu_data, WD3, pending;

    always #5 CLK = ~CLK;

    rf_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .RESET(RESET),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .rs1(rs1), .rs2(rs2), .dec_rd(dec_rd), .hazard(hazard),
        .A3(A3), .WD3(WD3), .WE3(WE3), .pending(pending)
    );

    typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

    exp_t        expq[$];   // expected RF writes, tagged with the cycle they were won
    ent_t        lq[$];     // model of the load FIFO
    logic [4:0]  outq[$];   // loads issued but not yet returned
    logic [31:0] pend = '0;
    int          starve = 0;
    int          cyc = 0;
    int          checks = 0, failures = 0;
    bit          alu_taken, lsu_taken, lsu_from_outq, last_alu_rdy, saw_full, mon_due;
    logic [4:0]  seq;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: a write won in cycle c must be visible in cycle c+1, and nothing else may write.
    always @(negedge CLK) begin
        if (!RESET) begin
            mon_due = (expq.size() > 0) && (expq[0].cyc == cyc - 1);
            chk("we3", {31'd0, WE3}, {31'd0, mon_due});
            if (mon_due) begin
                chk("a3", {27'd0, A3}, {27'd0, expq[0].rd});
                chk("wd3", WD3, expq[0].data);
                void'(expq.pop_front());
            end
        end
    end

    function automatic logic [4:0] pick_free(input logic [4:0] excl);
        int start = $urandom_range(1, 31);
        for (int i = 0; i < 31; i++) begin
            logic [4:0] r = 5'(((start - 1 + i) % 31) + 1);
            if (!pend[r] && r != excl) return r;
        end
        return 5'd0;
    endfunction

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0; lsu_from_outq = 0;
        ld_issue = 0; ld_issue_rd = 0; rs1 = 0; rs2 = 0; dec_rd = 0;
    endtask

    // One cycle: called at posedge+1 with inputs applied; checks, predicts, advances the model.
    task automatic step();
        int sz; bit lrdy, frc, aacc, fpop, lpush;
        #3;
        sz    = lq.size();
        lrdy  = sz < DEPTH;
        frc   = (sz > 0) && (starve == SM);
        aacc  = alu_valid && !frc;
        fpop  = (sz > 0) && !aacc;
        lpush = lsu_valid && lrdy && (lsu_rd != 0);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, aacc});
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, lrdy});
        chk("hazard", {31'd0, hazard}, {31'd0, pend[rs1] | pend[rs2] | pend[dec_rd]});
        chk("pending", pending, pend);
        if (!lsu_ready) saw_full = 1;
        last_alu_rdy = alu_ready;
        if (aacc && alu_rd != 0) expq.push_back('{alu_rd, alu_data, cyc});
        if (fpop) expq.push_back('{lq[0].rd, lq[0].data, cyc});
        alu_taken = aacc;
        lsu_taken = lsu_valid && lrdy;
        @(posedge CLK);
        if (fpop) begin pend[lq[0].rd] = 1'b0; void'(lq.pop_front()); end
        if (lpush) lq.push_back('{lsu_rd, lsu_data});
        if (aacc && sz > 0) starve = (starve < SM) ? starve + 1 : SM;
        else starve = 0;
        if (ld_issue && ld_issue_rd != 0) begin pend[ld_issue_rd] = 1'b1; outq.push_back(ld_issue_rd); end
        if (lsu_taken && lsu_from_outq) void'(outq.pop_front());
        #1;
    endtask

    task automatic do_reset();
        RESET = 1;
        alu_valid = 1; alu_rd = 5'd6; lsu_valid = 1; lsu_rd = 5'd5; ld_issue = 0;
        expq.delete(); lq.delete(); outq.delete();
        pend = '0; starve = 0;
        #3;
        chk("rst_we3", {31'd0, WE3}, 0);
        chk("rst_a3", {27'd0, A3}, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_pending", pending, 0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 0);
        @(posedge CLK); #1;
        chk("rst_hold_we3", {31'd0, WE3}, 0);
        idle();
        alu_taken = 0; lsu_taken = 0;
        RESET = 0;
    endtask

    // Next ALU result (held until accepted) and the next load return.
    task automatic gen_alu();
        if (!(alu_valid && !alu_taken)) begin
            alu_valid = 1;
            alu_rd    = ($urandom % 8 == 0) ? 5'd0 : pick_free(5'd0);
            alu_data  = $urandom;
        end
    endtask

    task automatic gen_lsu(input int pct);
        if (!(lsu_valid && !lsu_taken)) begin
            lsu_valid = 0; lsu_from_outq = 0;
            if (outq.size() > 0 && $urandom_range(0, 99) < pct) begin
                lsu_valid = 1; lsu_rd = outq[0]; lsu_data = $urandom; lsu_from_outq = 1;
            end else if ($urandom % 16 == 0) begin
                lsu_valid = 1; lsu_rd = 5'd0; lsu_data = $urandom;
            end
        end
    endtask

    initial begin
        idle();
        RESET = 1;
        @(posedge CLK); #1;
        do_reset();

        // ALU-only write to x5, then to x0.
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h12345678;
        step();
        idle();
        chk("alu5_we3", {31'd0, WE3}, 1);
        chk("alu5_a3", {27'd0, A3}, 5);
        chk("alu5_wd3", WD3, 32'h12345678);
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h0BADF00D;
        step();
        idle();
        chk("alu0_we3", {31'd0, WE3}, 0);

        // Load hazard on x7 and its writeback two edges after the return.
        ld_issue = 1; ld_issue_rd = 5'd7;
        step();
        idle();
        chk("pend7_set", {31'd0, pending[7]}, 1);
        rs1 = 5'd7; #1;
        chk("haz_rs1_7", {31'd0, hazard}, 1);
        step();
        idle();
        lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'hCAFEF00D; lsu_from_outq = 1;
        step();
        idle();
        step();
        chk("ld7_a3", {27'd0, A3}, 7);
        chk("ld7_wd3", WD3, 32'hCAFEF00D);
        chk("ld7_pend_clr", {31'd0, pending[7]}, 0);

        // Starvation: one queued load versus a continuously valid ALU.
        ld_issue = 1; ld_issue_rd = 5'd3;
        step();
        idle();
        lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h33333333; lsu_from_outq = 1;
        step();
        idle();
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'hA0000000;
        for (int i = 0; i < 5; i++) begin
            step();
            seq[i] = last_alu_rdy;
            if (alu_taken) alu_data = alu_data + 1;
        end
        chk("starve_seq", {27'd0, seq}, 32'b10111);
        idle();
        step();

        // Set and clear of x9 on the same edge: set must win.
        ld_issue = 1; ld_issue_rd = 5'd9;
        step();
        idle();
        lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99999999; lsu_from_outq = 1;
        step();
        idle();
        ld_issue = 1; ld_issue_rd = 5'd9;
        step();
        idle();
        chk("simul_pend9", {31'd0, pending[9]}, 1);

        // Fill to full behind a saturating ALU, drain, three times to wrap pointers.
        saw_full = 0;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 5; k++) begin
                ld_issue_rd = pick_free(5'd0);
                ld_issue = (ld_issue_rd != 0);
                step();
                idle();
            end
            for (int k = 0; k < 16; k++) begin
                gen_alu();
                gen_lsu(100);
                step();
            end
            idle();
            for (int k = 0; k < 8; k++) step();
        end
        chk("saw_full", {31'd0, saw_full}, 1);

        // Mid-stream reset with loads queued behind a busy ALU.
        for (int k = 0; k < 2; k++) begin
            ld_issue_rd = pick_free(5'd0);
            ld_issue = (ld_issue_rd != 0);
            step();
            idle();
        end
        for (int k = 0; k < 4; k++) begin
            gen_alu();
            gen_lsu(100);
            step();
        end
        do_reset();
        for (int k = 0; k < 4; k++) step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 4 == 0 && !(alu_valid && !alu_taken)) alu_valid = 0;
            else gen_alu();
            gen_lsu(50);
            ld_issue = 0;
            if ($urandom % 3 == 0) begin
                ld_issue_rd = pick_free(alu_valid ? alu_rd : 5'd0);
                ld_issue = (ld_issue_rd != 0);
            end
            rs1 = 5'($urandom); rs2 = 5'($urandom); dec_rd = 5'($urandom);
            step();
        end

        // Drain everything still outstanding.
        idle();
        for (int k = 0; k < 200 && (outq.size() > 0 || lq.size() > 0); k++) begin
            idle();
            gen_lsu(100);
            step();
        end
        idle();
        for (int k = 0; k < 4; k++) step();
        chk("drain_empty", expq.size() + lq.size() + outq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
